// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scanner: hex segment patterns,
// the all-off pattern and the digit index width helper.
package seven_segment_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n holds the pattern for hex digit n (entry 0 is the rightmost literal).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Width of the digit index; a single digit still needs one bit.
    function automatic int digit_idx_width(input int num_digits);
        if (num_digits <= 1) begin
            return 1;
        end
        return $clog2(num_digits);
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational hex-to-segment decoder with a blanking override.
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segments
);

    // Table lookup; blanking forces every segment off.
    always_comb begin
        segments = SEG_TABLE[nibble];
        if (blank) begin
            segments = SEG_OFF;
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: digit timing, double-buffered display
// data that only changes at frame boundaries, leading-zero blanking and
// PWM brightness, with all pin outputs registered.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic                      blank_lz,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic                      pending,
    output logic                      frame_start,
    output logic [6:0]                led_segment,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anode_activate
);

    localparam int VAL_W  = 4 * NUM_DIGITS;
    localparam int IDX_W  = digit_idx_width(NUM_DIGITS);
    localparam int TICK_W = $clog2(DIGIT_CYCLES);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]      tick_cnt;
    logic [IDX_W-1:0]       digit_idx;
    logic [BRIGHT_BITS-1:0] pwm_cnt;

    logic [VAL_W-1:0]       stage_value;
    logic [NUM_DIGITS-1:0]  stage_dp;
    logic [VAL_W-1:0]       disp_value;
    logic [NUM_DIGITS-1:0]  disp_dp;
    logic                   pending_q;

    logic                   tick_wrap;
    logic                   frame_edge;

    logic [NUM_DIGITS-1:0]  blank_mask;
    logic                   all_zero;

    logic [3:0]             sel_nibble;
    logic                   sel_dp;
    logic                   sel_blank;
    logic [NUM_DIGITS-1:0]  digit_onehot;
    logic                   drive_en;
    logic [6:0]             dec_segments;

    assign tick_wrap   = (tick_cnt == TICK_LAST);
    assign frame_edge  = tick_wrap && (digit_idx == IDX_LAST);
    assign frame_start = frame_edge;
    assign pending     = pending_q;

    // Slot timer, digit index and free-running PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick_wrap) begin
                tick_cnt <= '0;
                if (digit_idx == IDX_LAST) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Staging and display registers; the display only changes at a frame
    // boundary, and a load landing on the boundary goes straight through.
    // Staging also takes that load so the next boundary re-copies the same data.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_value <= '0;
            stage_dp    <= '0;
            disp_value  <= '0;
            disp_dp     <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (load) begin
                stage_value <= value;
                stage_dp    <= dp_mask;
            end
            if (frame_edge) begin
                pending_q <= 1'b0;
                if (load) begin
                    disp_value <= value;
                    disp_dp    <= dp_mask;
                end else begin
                    disp_value <= stage_value;
                    disp_dp    <= stage_dp;
                end
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Digit i (i>0) is blankable when it and every digit to its left are zero.
    always_comb begin
        blank_mask = '0;
        all_zero   = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            all_zero = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (disp_value[j*4 +: 4] != 4'h0) begin
                    all_zero = 1'b0;
                end
            end
            blank_mask[i] = all_zero;
        end
    end

    // Pick the nibble, dp and anode of the digit currently being scanned.
    always_comb begin
        sel_nibble   = 4'h0;
        sel_dp       = 1'b0;
        sel_blank    = 1'b0;
        digit_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                sel_nibble      = disp_value[i*4 +: 4];
                sel_dp          = disp_dp[i];
                sel_blank       = blank_lz & blank_mask[i];
                digit_onehot[i] = 1'b1;
            end
        end
    end

    // Anode drive window: PWM duty, and never during the first tick of a slot.
    always_comb begin
        drive_en = (pwm_cnt <= brightness) && (tick_cnt != '0);
    end

    seven_segment_decode u_decode (
        .nibble   (sel_nibble),
        .blank    (sel_blank),
        .segments (dec_segments)
    );

    // Pin registers: one cycle from scan state to the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_segment    <= SEG_OFF;
            dp             <= 1'b1;
            anode_activate <= '1;
        end else begin
            led_segment    <= dec_segments;
            dp             <= ~sel_dp;
            anode_activate <= ~(digit_onehot & {NUM_DIGITS{drive_en}});
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner with a cycle-count based
// reference model.
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int DC = 8;
    localparam int BB = 2;
    localparam int FRAME = ND * DC;

    logic          clk;
    logic          reset;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_mask;
    logic          blank_lz;
    logic [1:0]    brightness;
    logic          pending;
    logic          frame_start;
    logic [6:0]    led_segment;
    logic          dp;
    logic [3:0]    anode_activate;

    seven_segment_scanner #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .BRIGHT_BITS  (BB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .value          (value),
        .dp_mask        (dp_mask),
        .blank_lz       (blank_lz),
        .brightness     (brightness),
        .pending        (pending),
        .frame_start    (frame_start),
        .led_segment    (led_segment),
        .dp             (dp),
        .anode_activate (anode_activate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference patterns for hex digits 0..F, {g,f,e,d,c,b,a} active-low.
    logic [6:0] hex_seg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          checks;
    int          failures;
    int          cyc;
    int          cyc_total;
    bit          model_valid;
    logic [15:0] staged_v;
    logic [3:0]  staged_dp;
    logic [15:0] shown_v;
    logic [3:0]  shown_dp;
    logic        pend;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_fs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_total);
        end
    endtask

    // Model: scan position is a pure function of cycles since reset release.
    task automatic model_update();
        int tick;
        int idx;
        int pwm;
        logic [15:0] upper;
        if (reset) begin
            cyc         = 0;
            staged_v    = '0;
            staged_dp   = '0;
            shown_v     = '0;
            shown_dp    = '0;
            pend        = 1'b0;
            exp_seg     = 7'h7F;
            exp_dp      = 1'b1;
            exp_an      = 4'hF;
            model_valid = 1'b1;
        end else begin
            tick  = cyc % DC;
            idx   = (cyc / DC) % ND;
            pwm   = cyc % (1 << BB);
            upper = shown_v >> (4 * idx);
            if (blank_lz && idx > 0 && upper == 16'h0)
                exp_seg = 7'h7F;
            else
                exp_seg = hex_seg[upper & 16'hF];
            exp_dp = ~shown_dp[idx];
            exp_an = (tick != 0 && pwm <= int'(brightness)) ? ~(4'b0001 << idx) : 4'hF;
            if (cyc % FRAME == FRAME - 1) begin
                if (load) begin
                    shown_v   = value;
                    shown_dp  = dp_mask;
                    staged_v  = value;
                    staged_dp = dp_mask;
                end else begin
                    shown_v  = staged_v;
                    shown_dp = staged_dp;
                end
                pend = 1'b0;
            end else if (load) begin
                staged_v  = value;
                staged_dp = dp_mask;
                pend      = 1'b1;
            end
            cyc++;
        end
        exp_fs = (cyc % FRAME) == FRAME - 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc_total++;
        @(negedge clk);
        if (model_valid) begin
            check_val("led_segment", 32'(led_segment), 32'(exp_seg));
            check_val("dp", 32'(dp), 32'(exp_dp));
            check_val("anode", 32'(anode_activate), 32'(exp_an));
            check_val("pending", 32'(pending), 32'(pend));
            check_val("frame_start", 32'(frame_start), 32'(exp_fs));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to_slot(input int target);
        for (int k = 0; k < FRAME && (cyc % FRAME) != target; k++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        load    = 1'b1;
        value   = v;
        dp_mask = m;
        step();
        load    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rv;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        cyc_total   = 0;
        model_valid = 1'b0;
        reset       = 1'b1;
        load        = 1'b0;
        value       = '0;
        dp_mask     = '0;
        blank_lz    = 1'b0;
        brightness  = 2'd3;
        @(negedge clk);
        run(3);
        reset = 1'b0;

        // 1234 at full brightness
        do_load(16'h1234, 4'b0000);
        run(2 * FRAME + 4);

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b1010);
        run(2 * FRAME);

        // last staged value wins; the first never reaches the display
        run_to_slot(10);
        do_load(16'hAAAA, 4'b0001);
        run_to_slot(20);
        do_load(16'h5555, 4'b0100);
        run(2 * FRAME);

        // minimum brightness
        brightness = 2'd0;
        run(FRAME);
        brightness = 2'd1;
        run(FRAME);
        brightness = 2'd3;

        // load on the boundary cycle
        run_to_slot(FRAME - 1);
        do_load(16'h9C0E, 4'b1111);
        run(FRAME + 2);

        // reset mid-frame at index 2, tick 5, with a load in the same cycle
        run_to_slot(2 * DC + 5);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        step();
        reset = 1'b0;
        load  = 1'b0;
        run(FRAME + 4);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            load = ($urandom_range(0, 5) == 0);
            rv   = 16'($urandom());
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 1) == 0) rv[n*4 +: 4] = 4'h0;
            value   = rv;
            dp_mask = 4'($urandom());
            if ($urandom_range(0, 40) == 0) blank_lz = 1'($urandom());
            if ($urandom_range(0, 50) == 0) brightness = 2'($urandom());
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        load  = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter DIGIT_CYCLES, default 100000: clk cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter BRIGHT_BITS, default 4: width of the brightness control, minimum 1.
REQ-004 SHALL have port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port load  input  1: single-cycle request to stage value and dp_mask.
REQ-007 SHALL have port value  input  4*NUM_DIGITS: hex nibbles; nibble 0 is the rightmost digit.
REQ-008 SHALL have port dp_mask  input  NUM_DIGITS: decimal point enable per digit, 1 = lit.
REQ-009 SHALL have port blank_lz  input  1: leading-zero blanking enable.
REQ-010 SHALL have port brightness  input  BRIGHT_BITS: PWM duty code.
REQ-011 SHALL have port pending  output  1: staged data not yet displayed.
REQ-012 SHALL have port frame_start  output  1: one-cycle pulse at each frame boundary.
REQ-013 SHALL have port led_segment  output  7: segments {g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port dp  output  1: decimal point, active-low.
REQ-015 SHALL have port anode_activate  output  NUM_DIGITS: digit enables, active-low.

Function
REQ-016 SHALL count tick_cnt 0..DIGIT_CYCLES-1, wrapping to 0; on the wrap, digit index SHALL advance 0..NUM_DIGITS-1 and then wrap to 0.
REQ-017 SHALL define the frame boundary as the cycle in which the index wraps from NUM_DIGITS-1 to 0; frame_start SHALL be high in exactly that cycle.
REQ-018 SHALL capture value/dp_mask into a staging register on load and set pending the following cycle; repeated loads before a boundary SHALL overwrite staging (last wins).
REQ-019 SHALL copy staging to the display register at the frame boundary and clear pending; the display register SHALL never change at any other time (no tearing).
REQ-020 On load coincident with the boundary, the display register SHALL take the load-cycle inputs directly and pending SHALL stay 0.
REQ-021 SHALL decode the selected display nibble to standard hex patterns 0-F.
REQ-022 With blank_lz=1, digit i>0 SHALL show all segments off if nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be blanked; dp SHALL follow dp_mask regardless.
REQ-023 SHALL run a free-running BRIGHT_BITS-wide pwm_cnt; the selected anode SHALL be active only when pwm_cnt <= brightness, so all-ones gives full duty.
REQ-024 SHALL hold all anodes inactive while tick_cnt==0 (ghosting guard), regardless of brightness.
REQ-025 SHALL register led_segment, dp and anode_activate, giving exactly one cycle of latency from index/tick/pwm state to the pins.
REQ-026 SHALL ignore brightness and blank_lz changes for timing purposes; they take effect on the next registered output cycle.

Reset
REQ-027 While reset=1: tick_cnt, index, pwm_cnt, staging and display registers SHALL be 0; pending=0; frame_start=0; led_segment=7'h7F; dp=1; anode_activate all ones.
REQ-028 Reset asserted mid-frame SHALL take effect on the next edge; a load in the same cycle as reset SHALL be discarded.

Structure
REQ-029 The 16-entry segment pattern table, the SEG_OFF constant and the digit-index width function SHALL live in package seven_segment_pkg.
REQ-030 Hex decoding SHALL be a combinational sub-module, seven_segment_decode; the counters, staging logic and output registers SHALL stay in the top.

Verification (NUM_DIGITS=4, DIGIT_CYCLES=8, BRIGHT_BITS=2)
REQ-031 Reset, then load 16'h1234, brightness=3 -> after the next frame_start, the digit-0 slot shows anode 4'b1110 and led_segment 7'b0011001 ("4") for ticks 1..7, with anodes off on tick 0.
REQ-032 Load 16'h0050 with blank_lz=1 -> digits 3 and 2 show 7'h7F; digit 1 shows 7'b0010010 ("5"); digit 0 shows 7'b1000000 ("0").
REQ-033 Load 16'hAAAA mid-frame, then 16'h5555 before the boundary -> pending=1 until frame_start; display shows 5555 only from that boundary; AAAA never appears.
REQ-034 brightness=0 -> the selected anode is active 1 in every 4 cycles; brightness=3 -> active on every tick except 0.
REQ-035 Load asserted exactly on the frame_start cycle -> the new value is shown in the same frame and pending never rises.
REQ-036 Reset pulsed at index 2, tick 5 -> the next cycle has all anodes 1 and led_segment 7'h7F; after release, scanning restarts at index 0, tick 0 with the display showing 0.
